// File: rtl/aes_keyslot_ctrl_if.sv
// Register access bus between the AXI-lite adapter and the key-slot controller.
// rdata is combinational and only meaningful while en is high.
interface aes_keyslot_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output en, output we, output addr, output wdata, input rdata);
    modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/aes_keyslot_ctrl.sv
// MMIO front end and start/busy/done sequencer for a 128-bit block cipher core:
// write-only key slots, PT/CT registers, timeout, zeroization and interrupt.
module aes_keyslot_ctrl #(
    parameter int NUM_KEYS  = 4,
    parameter int KEY_WORDS = 6,
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    aes_keyslot_ctrl_if.slave      bus,
    input  logic [3:0]             reglk_i,
    input  logic                   debug_mode_i,
    output logic                   core_start_o,
    output logic [127:0]           core_pt_o,
    output logic [32*KEY_WORDS-1:0] core_key_o,
    input  logic [127:0]           core_ct_i,
    input  logic                   core_valid_i,
    output logic                   irq_o,
    output logic [1:0]             dbg_state_o
);
    localparam int NKW      = NUM_KEYS * KEY_WORDS;
    localparam int KI_W     = $clog2(NKW);
    localparam int KEY_BASE = 16;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, ZERO = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [KI_W-1:0] zidx_q, zidx_d;
    logic [31:0]     key_q [NKW];
    logic [31:0]     key_d [NKW];
    logic [31:0]     pt_q [4];
    logic [31:0]     pt_d [4];
    logic [31:0]     ct_q [4];
    logic [31:0]     ct_d [4];
    logic [2:0]      key_sel_q, key_sel_d;
    logic            irq_en_q, irq_en_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [31:0]     a32;
    logic            wr, busy, sel_ok, ctrl_wr, pt_hit, ct_hit, key_hit;
    logic [KI_W-1:0] kidx;

    assign a32     = 32'(bus.addr);
    assign wr      = bus.en & bus.we;
    assign busy    = (state_q != IDLE);
    assign sel_ok  = 32'(key_sel_q) < 32'(NUM_KEYS);
    assign ctrl_wr = wr && (a32 == 32'd0) && !reglk_i[2];
    assign pt_hit  = (a32 >= 32'd4) && (a32 <= 32'd7);
    assign ct_hit  = (a32 >= 32'd8) && (a32 <= 32'd11);
    assign key_hit = (a32 >= 32'(KEY_BASE)) && (a32 < 32'(KEY_BASE + NKW));
    assign kidx    = KI_W'(a32 - 32'(KEY_BASE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            zidx_q    <= '0;
            key_sel_q <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NKW; i++) key_q[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                pt_q[i] <= '0;
                ct_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            zidx_q    <= zidx_d;
            key_sel_q <= key_sel_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            key_q     <= key_d;
            pt_q      <= pt_d;
            ct_q      <= ct_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        zidx_d    = zidx_q;
        key_d     = key_q;
        pt_d      = pt_q;
        ct_d      = ct_q;
        key_sel_d = key_sel_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;

        // Software writes first so that hardware status updates below override w1c.
        if (ctrl_wr) irq_en_d = bus.wdata[2];
        if (wr && a32 == 32'd1) begin
            if (bus.wdata[2]) err_d = 1'b0;
            if (bus.wdata[1]) done_d = 1'b0;
        end
        if (wr && !busy) begin
            if (a32 == 32'd2) key_sel_d = bus.wdata[2:0];
            if (pt_hit && !reglk_i[0]) pt_d[a32[1:0]] = bus.wdata;
            if (key_hit && !reglk_i[1]) key_d[kidx] = bus.wdata;
        end

        case (state_q)
            IDLE: begin
                if (ctrl_wr && bus.wdata[1]) begin
                    state_d = ZERO;
                    zidx_d  = '0;
                    for (int i = 0; i < 4; i++) begin
                        pt_d[i] = '0;
                        ct_d[i] = '0;
                    end
                end else if (ctrl_wr && bus.wdata[0]) begin
                    if (debug_mode_i || !sel_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (core_valid_i) begin
                    for (int i = 0; i < 4; i++) ct_d[i] = core_ct_i[32*i +: 32];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ZERO: begin
                key_d[zidx_q] = '0;
                if (zidx_q == KI_W'(NKW - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    zidx_d = zidx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.en) begin
            if (a32 == 32'd0)      bus.rdata = {29'd0, irq_en_q, 2'b00};
            else if (a32 == 32'd1) bus.rdata = {29'd0, err_q, done_q, busy};
            else if (a32 == 32'd2) bus.rdata = {29'd0, key_sel_q};
            else if (pt_hit)       bus.rdata = pt_q[a32[1:0]];
            else if (ct_hit)       bus.rdata = reglk_i[3] ? 32'd0 : ct_q[a32[1:0]];
        end
    end

    // Key leaves the block only for a valid slot and never while debug is active.
    always_comb begin
        core_key_o = '0;
        if (sel_ok && !debug_mode_i) begin
            for (int w = 0; w < KEY_WORDS; w++)
                core_key_o[32*(KEY_WORDS-1-w) +: 32] = key_q[KI_W'(32'(key_sel_q) * KEY_WORDS + w)];
        end
    end

    assign core_start_o = (state_q == LOAD);
    assign core_pt_o    = {pt_q[3], pt_q[2], pt_q[1], pt_q[0]};
    assign irq_o        = irq_en_q & (done_q | err_q);
    assign dbg_state_o  = state_q;
endmodule
